net_fanout_collector: RTL
=========================

Name: net_fanout_collector

Overview:
- Inverse of the per-instance gate-net listing used by the placer testcases.
- Consumes a stream of (instance -> gate net) records and accumulates a fanout count per net.
- After the final record, emits a net-ordered stream of (net, count) pairs.
- Sits between the testcase netlist loader and the placer's net-weighting stage.

Parameters:
- NET_W, 4, net index width; 2**NET_W count slots.
- CNT_W, 5, per-net counter width; saturating.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  record valid.
- in_ready  output  1  collector can accept a record.
- in_net  input  NET_W  gate net of the record.
- in_last  input  1  final record of the netlist.
- out_valid  output  1  (net, count) pair valid.
- out_ready  input  1  downstream accepts the pair.
- out_net  output  NET_W  net index.
- out_count  output  CNT_W  instances on that net.
- out_last  output  1  final pair of the drain.
- busy  output  1  high in ACCUM or DRAIN.
- overflow  output  1  sticky; some counter saturated during this netlist.

Behaviour:
- States: IDLE, ACCUM, DRAIN. All state is registered; asynchronous reset clears every flop.
- Reset values:
  - state=IDLE.
  - All counters 0, ptr=0.
  - in_ready=1, out_valid=0, out_net=0, out_count=0, out_last=0, busy=0, overflow=0.
- Accept rule: a record is accepted on a clk edge with in_valid&in_ready.
  - in_ready=1 in IDLE and ACCUM, 0 in DRAIN.
  - in_ready does not depend on in_valid.
- Counting: accepted record does cnt[in_net] <= cnt[in_net]+1, visible next cycle.
  - At all-ones the counter holds its value and overflow sets.
  - overflow clears only on reset or on entry to IDLE from DRAIN.
- Transitions:
  - IDLE -> ACCUM on an accept with in_last=0.
  - IDLE or ACCUM -> DRAIN on an accept with in_last=1. That record is counted.
  - ACCUM holds when there is no accept.
  - DRAIN -> IDLE on the handshake of the out_last pair.
- DRAIN entry: on the in_last accept edge, ptr is loaded with the lowest net whose count is nonzero, including the final record's increment.
  - out_valid=1 from the next cycle: one-cycle latency from the last accept to the first pair.
- DRAIN outputs:
  - out_net=ptr and out_count=cnt[ptr], both driven from registers.
  - On out_valid&out_ready, ptr advances to the next nonzero net above ptr.
  - out_last=1 when no nonzero net exists above ptr.
  - out_valid stays high and outputs stay stable while out_ready=0.
- Drain order: strictly ascending net index, one pair per handshake cycle at most.
- On the out_last handshake:
  - All counters clear in that same edge, ptr=0, overflow=0.
  - out_valid=0 next cycle, in_ready=1 next cycle.
- Boundaries:
  - A one-record netlist (in_last on the first accept) drains exactly one pair with count 1.
  - in_valid during DRAIN is ignored and the data is not consumed.
  - rst asserted mid-ACCUM or mid-DRAIN discards all counts immediately, outputs take reset values, and no partial pairs are emitted.
  - out_ready held high gives back-to-back pairs.

Optional Feature:
- Macro: NET_FANOUT_SKIP_ZERO_EN.
- Defined: DRAIN emits only nets with nonzero count, as described above.
- Undefined:
  - DRAIN emits every net 0 .. 2**NET_W-1, including zero counts.
  - ptr starts at 0 and increments by 1.
  - out_last is asserted at net 2**NET_W-1.
  - Drain always takes exactly 2**NET_W handshakes.

Test Plan:
- Stream nets 0,2,2,3,3,3,3,4,4,4,4,5,5,1, with in_last on the 14th record and out_ready=1 -> pairs (0,1),(1,1),(2,2),(3,4),(4,4),(5,2); out_last only on net 5; first out_valid one cycle after the in_last accept. Without the macro -> 16 pairs, nets 6..15 have count 0.
- Single record net 7 with in_last -> one pair (7,1) with out_last; returns to IDLE with in_ready=1 the following cycle.
- Send 33 records all on net 9 (CNT_W=5) -> count saturates at 31, overflow=1 through the drain, cleared after the out_last handshake.
- Toggle out_ready 1,0,0,1 during drain -> outputs held stable while stalled; no pair dropped or duplicated; in_valid pulses during DRAIN see in_ready=0 and are not counted.
- Assert rst after 5 records in ACCUM, then stream net 3 with in_last -> exactly one pair (3,1); no residue from before the reset.
- Two consecutive netlists back-to-back -> the second drain reflects only the second netlist's counts.

Source files
------------

// File: rtl/net_fanout_collector.sv
// Accumulates per-net fanout counts from a record stream, then drains (net, count) pairs in ascending net order.
// Define NET_FANOUT_SKIP_ZERO_EN to drain only nonzero nets; otherwise every net 0..2**NET_W-1 is emitted.
module net_fanout_collector #(
  parameter int NET_W = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NET_W-1:0] in_net,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NET_W-1:0] out_net,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic             busy,
  output logic             overflow
);

  localparam int SLOTS = 2 ** NET_W;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [SLOTS];
  logic [CNT_W-1:0] cnt_d [SLOTS];
  logic [NET_W-1:0] ptr_q, ptr_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             pop;
  logic             has_above;
  logic [NET_W-1:0] next_above;
  logic [NET_W-1:0] entry_ptr;

  assign in_ready  = (state_q != S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DRAIN);
  assign out_net   = ptr_q;
  assign out_count = out_valid ? cnt_q[ptr_q] : '0;
  assign out_last  = out_valid && !has_above;
  assign overflow  = overflow_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

`ifdef NET_FANOUT_SKIP_ZERO_EN
  // Nearest nonzero net strictly above the drain pointer.
  always_comb begin
    has_above  = 1'b0;
    next_above = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if ((i > int'(ptr_q)) && (cnt_q[i] != '0)) begin
        has_above  = 1'b1;
        next_above = NET_W'(i);
      end
    end
  end

  // Lowest nonzero net after the final record has been counted.
  always_comb begin
    entry_ptr = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (cnt_d[i] != '0) entry_ptr = NET_W'(i);
    end
  end
`else
  assign has_above  = (ptr_q != {NET_W{1'b1}});
  assign next_above = ptr_q + 1'b1;
  assign entry_ptr  = '0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    overflow_d = overflow_q;
    for (int i = 0; i < SLOTS; i++) cnt_d[i] = cnt_q[i];

    if (accept) begin
      if (cnt_q[in_net] == CNT_MAX) overflow_d = 1'b1;
      else                          cnt_d[in_net] = cnt_q[in_net] + 1'b1;
    end

    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          if (in_last) begin
            state_d = S_DRAIN;
            ptr_d   = entry_ptr;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_DRAIN: begin
        if (pop) begin
          if (out_last) begin
            // Closing handshake wipes the table so the next netlist starts clean.
            state_d    = S_IDLE;
            ptr_d      = '0;
            overflow_d = 1'b0;
            for (int i = 0; i < SLOTS; i++) cnt_d[i] = '0;
          end else begin
            ptr_d = next_above;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < SLOTS; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < SLOTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
